// File: rtl/scan_sequencer_if.sv
// Handshake bundle between a scan controller and the scan_sequencer.
//   run/dir/step : controller -> sequencer (scan requests)
//   A/B/C        : decoder select bits, LSB first
//   G1/G2A/G2B   : decoder enables, identical, high = enabled
//   busy         : slot (SHOW or BLANK) in progress
//   wrap         : one-cycle pulse when the slot index wraps
interface scan_sequencer_if;
  logic run;
  logic dir;
  logic step;
  logic A;
  logic B;
  logic C;
  logic G1;
  logic G2A;
  logic G2B;
  logic busy;
  logic wrap;

  modport master (
    output run, dir, step,
    input  A, B, C, G1, G2A, G2B, busy, wrap
  );

  modport slave (
    input  run, dir, step,
    output A, B, C, G1, G2A, G2B, busy, wrap
  );
endinterface

// File: rtl/scan_sequencer.sv
// Slot sequencer for a 3-to-8 decoder stage. Steps a 3-bit select index through 0..LAST and
// opens the decoder enables for DIV cycles per slot, followed by a BLANK-cycle gap.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scan_sequencer_if.slave (run/dir/step in; A/B/C, G1/G2A/G2B, busy, wrap out)
module scan_sequencer #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1,
  parameter int unsigned LAST  = 7
) (
  input logic             clk,
  input logic             rst_n,
  scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

  localparam logic [2:0]  LastIdx  = 3'(LAST);
  localparam logic [15:0] ShowEnd  = 16'(DIV - 1);
  localparam logic [15:0] BlankEnd = 16'(BLANK - 1);

  state_e      state_q;
  logic [2:0]  index_q;
  logic [15:0] cnt_q;
  logic        en_q;
  logic        busy_q;
  logic        wrap_q;

  logic [2:0]  index_adv;
  logic        index_wraps;

  // Next index for the SHOW -> BLANK edge, using dir as sampled at that edge.
  always_comb begin
    index_adv   = index_q;
    index_wraps = 1'b0;
    if (!bus.dir) begin
      if (index_q == LastIdx) begin
        index_adv   = 3'd0;
        index_wraps = 1'b1;
      end else begin
        index_adv = index_q + 3'd1;
      end
    end else begin
      if (index_q == 3'd0) begin
        index_adv   = LastIdx;
        index_wraps = 1'b1;
      end else begin
        index_adv = index_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      index_q <= 3'd0;
      cnt_q   <= 16'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // run and step both start a slot; run alone decides whether scanning continues.
          if (bus.run || bus.step) begin
            state_q <= StShow;
            cnt_q   <= 16'd0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == ShowEnd) begin
            // Index moves only while the decoder is being disabled.
            state_q <= StBlank;
            cnt_q   <= 16'd0;
            en_q    <= 1'b0;
            index_q <= index_adv;
            wrap_q  <= index_wraps;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StBlank: begin
          if (cnt_q == BlankEnd) begin
            cnt_q <= 16'd0;
            if (bus.run) begin
              state_q <= StShow;
              en_q    <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A    = index_q[0];
  assign bus.B    = index_q[1];
  assign bus.C    = index_q[2];
  assign bus.G1   = en_q;
  assign bus.G2A  = en_q;
  assign bus.G2B  = en_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  scan_sequencer_if bus0 ();
  scan_sequencer_if bus1 ();

  scan_sequencer dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  scan_sequencer #(
    .DIV  (2),
    .BLANK(3),
    .LAST (4)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  logic [2:0] abc0, abc1;
  assign abc0 = {bus0.C, bus0.B, bus0.A};
  assign abc1 = {bus1.C, bus1.B, bus1.A};

  typedef struct {
    int         len;
    logic [2:0] show;
    logic [2:0] after;
    logic       wrap;
  } slot_t;

  slot_t q0[$];
  slot_t q1[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Per-DUT monitor state
  logic       prev[2];
  int         wlen[2];
  logic [2:0] wshow[2];
  logic       wbad[2];
  int         last_wrap[2];
  int         wrap_per[2];
  logic       have_wrap[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input int len, input int show, input int after,
                      input logic wr);
    slot_t e;
    e.len   = len;
    e.show  = 3'(show);
    e.after = 3'(after);
    e.wrap  = wr;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // A slot is complete when the enables fall; at that sample the index has already advanced
  // and wrap (if any) is high.
  task automatic mon(input int id, input logic g1, input logic g2a, input logic g2b,
                     input logic bsy, input logic wr, input logic [2:0] abc);
    slot_t e;
    bit    got;
    got = 1'b0;
    if (wr) begin
      if (have_wrap[id]) wrap_per[id] = cyc - last_wrap[id];
      last_wrap[id] = cyc;
      have_wrap[id] = 1'b1;
    end
    if (g1) begin
      if (!prev[id]) begin
        wlen[id]  = 0;
        wshow[id] = abc;
        wbad[id]  = 1'b0;
      end
      wlen[id]++;
      if (abc != wshow[id] || g2a != g1 || g2b != g1 || !bsy) wbad[id] = 1'b1;
    end else if (prev[id]) begin
      n_vec++;
      if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        n_fail++;
        $display("FAIL slot%0d: unexpected window abc=%0d len=%0d, required none",
                 id, wshow[id], wlen[id]);
      end else if (wlen[id] != e.len || wshow[id] != e.show || abc != e.after ||
                   wr != e.wrap || wbad[id]) begin
        n_fail++;
        $display("FAIL slot%0d: got len=%0d abc=%0d next=%0d wrap=%0d bad=%0d, required len=%0d abc=%0d next=%0d wrap=%0d bad=0",
                 id, wlen[id], wshow[id], abc, wr, wbad[id], e.len, e.show, e.after, e.wrap);
      end
    end else if (wr) begin
      n_vec++;
      n_fail++;
      $display("FAIL wrap%0d: stray pulse at cycle %0d, required none", id, cyc);
    end
    prev[id] = g1;
  endtask

  initial begin
    prev[0] = 1'b0; prev[1] = 1'b0;
    have_wrap[0] = 1'b0; have_wrap[1] = 1'b0;
    wrap_per[0] = 0; wrap_per[1] = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev[0] = 1'b0;
      prev[1] = 1'b0;
    end else begin
      mon(0, bus0.G1, bus0.G2A, bus0.G2B, bus0.busy, bus0.wrap, abc0);
      mon(1, bus1.G1, bus1.G2A, bus1.G2B, bus1.busy, bus1.wrap, abc1);
    end
  end

  task automatic wait_qsize(input int id, input int size, input int budget, input string name);
    int n;
    n = 0;
    while ((id == 0 ? q0.size() : q1.size()) > size && n < budget) begin
      n++;
      @(negedge clk);
    end
    chk(name, (id == 0 ? q0.size() : q1.size()), size);
  endtask

  task automatic wait_g1_0(input string name);
    int n;
    n = 0;
    while (!bus0.G1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(name, int'(bus0.G1), 1);
  endtask

  initial begin
    int n;
    bus0.run = 1'b0; bus0.dir = 1'b0; bus0.step = 1'b0;
    bus1.run = 1'b0; bus1.dir = 1'b0; bus1.step = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_en", int'({bus0.G1, bus0.G2A, bus0.G2B}), 0);
    chk("rst_busy_wrap", int'({bus0.busy, bus0.wrap}), 0);
    chk("rst_abc", int'(abc0), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", int'({bus0.G1, bus0.busy}), 0);

    // Down scan from 0: first advance wraps to 7
    bus0.dir = 1'b1;
    bus0.run = 1'b1;
    push(0, 4, 0, 7, 1'b1);
    push(0, 4, 7, 6, 1'b0);
    push(0, 4, 6, 5, 1'b0);
    wait_qsize(0, 0, 100, "down_drain");
    wait_g1_0("down_show5_open");
    chk("down_show5_abc", int'(abc0), 5);

    // Asynchronous reset in the 2nd SHOW cycle at index 5
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", int'({bus0.G1, bus0.G2A, bus0.G2B}), 0);
    chk("async_rst_busy_wrap", int'({bus0.busy, bus0.wrap}), 0);
    chk("async_rst_abc", int'(abc0), 0);
    bus0.run = 1'b0;
    bus0.dir = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", int'({bus0.G1, bus0.busy}), 0);
    chk("post_rst_abc", int'(abc0), 0);

    // Single steps 0->1, 1->2
    for (int i = 0; i < 2; i++) begin
      push(0, 4, i, i + 1, 1'b0);
      @(negedge clk); bus0.step = 1'b1;
      @(negedge clk); bus0.step = 1'b0;
      n = 0;
      while (bus0.busy && n < 30) begin n++; @(negedge clk); end
    end
    // Step at index 2, with a second step during busy that must be ignored
    push(0, 4, 2, 3, 1'b0);
    @(negedge clk); bus0.step = 1'b1;
    @(negedge clk); bus0.step = 1'b0;
    n = 0;
    while (bus0.busy && n < 30) begin
      n++;
      if (n == 2) bus0.step = 1'b1;
      if (n == 3) bus0.step = 1'b0;
      @(negedge clk);
    end
    chk("step_busy_len", n, 5);
    repeat (6) @(negedge clk);
    chk("step_then_idle", int'({bus0.G1, bus0.busy}), 0);
    chk("step_idx", int'(abc0), 3);
    chk("step_drain", q0.size(), 0);

    // Continuous up scan from 3, two wraps, graceful stop at index 3
    bus0.run = 1'b1;
    for (int i = 3; i < 8; i++) push(0, 4, i, (i + 1) % 8, i == 7);
    for (int i = 0; i < 8; i++) push(0, 4, i, (i + 1) % 8, i == 7);
    for (int i = 0; i < 4; i++) push(0, 4, i, i + 1, 1'b0);
    wait_qsize(0, 1, 300, "up_reach_slot3");
    wait_g1_0("up_show3_open");
    @(negedge clk);
    bus0.run = 1'b0;
    wait_qsize(0, 0, 30, "stop_drain");
    repeat (4) @(negedge clk);
    chk("stop_idle", int'({bus0.G1, bus0.busy}), 0);
    chk("stop_idx", int'(abc0), 4);
    chk("up_frame_period", wrap_per[0], 40);

    // Variant LAST=4, DIV=2, BLANK=3
    @(negedge clk);
    bus1.run = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 5; i++) push(1, 2, i, (i + 1) % 5, i == 4);
    wait_qsize(1, 0, 200, "var_drain");
    bus1.run = 1'b0;
    repeat (8) @(negedge clk);
    chk("var_idle", int'({bus1.G1, bus1.busy}), 0);
    chk("var_idx", int'(abc1), 0);
    chk("var_frame_period", wrap_per[1], 25);
    chk("var_no_extra_slot", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
